note_entry: RTL and testbench

//  Front-end stage feeding the note-sequence classifier FSM (the block consuming ok/tom/nota).

---
 rtl/note_entry_pkg.sv | 35 +++
 rtl/note_entry_if.sv | 35 +++
 rtl/note_entry_debounce_sync.sv | 55 +++++
 rtl/note_entry.sv | 127 ++++++++++++
 tb/tb_note_entry.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/note_entry_pkg.sv
// -----------------------------------------------------------------------------
// note_entry_pkg
// Shared definitions for the note entry front-end: note and tone codes, the
// default sequence length and the sequencing FSM state encodings.
// -----------------------------------------------------------------------------
package note_entry_pkg;

    // Note codes as presented on the 3-bit note switches.
    typedef enum logic [2:0] {
        NOTA_X   = 3'b000,  // sequence terminator
        NOTA_DO  = 3'b001,
        NOTA_RE  = 3'b010,
        NOTA_MI  = 3'b011,
        NOTA_FA  = 3'b100,
        NOTA_SOL = 3'b101,
        NOTA_LA  = 3'b110,
        NOTA_SI  = 3'b111
    } nota_e;

    // Tone switch codes.
    localparam logic TOM_LOW  = 1'b0;
    localparam logic TOM_HIGH = 1'b1;

    localparam int NOTA_W            = 3;
    localparam int COUNT_W           = 3;
    localparam int MAX_NOTES_DEF     = 6;
    localparam int DEBOUNCE_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HELD = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/note_entry_if.sv
// -----------------------------------------------------------------------------
// note_entry_if
// Bundles the raw board inputs and the cleaned classifier-facing outputs of
// note_entry.
//   btn_ok, sw_tom, sw_nota : raw asynchronous board inputs
//   ok                      : one-cycle note-accepted strobe
//   tom, nota               : registered tone/note, valid with ok
//   count                   : strobes issued in the current sequence
//   done                    : sequence closed
// modport master : the note_entry block (consumes raw inputs, drives outputs)
// modport slave  : the board / consumer side
// -----------------------------------------------------------------------------
interface note_entry_if;
    import note_entry_pkg::*;

    logic                btn_ok;
    logic                sw_tom;
    logic [NOTA_W-1:0]   sw_nota;
    logic                ok;
    logic                tom;
    logic [NOTA_W-1:0]   nota;
    logic [COUNT_W-1:0]  count;
    logic                done;

    modport master (
        input  btn_ok, sw_tom, sw_nota,
        output ok, tom, nota, count, done
    );

    modport slave (
        output btn_ok, sw_tom, sw_nota,
        input  ok, tom, nota, count, done
    );

endinterface

// File: rtl/note_entry_debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
// Two-flop synchronizer followed by a level debouncer. The output level only
// changes after the synchronized input has differed from it for
// DEBOUNCE_CYCLES consecutive clocks; any shorter excursion restarts the count.
//   clk   : system clock
//   reset : synchronous, active-high
//   din   : raw asynchronous input
//   dout  : debounced level
// -----------------------------------------------------------------------------
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/note_entry.sv
// -----------------------------------------------------------------------------
// note_entry
// Front-end for the note-sequence classifier. Debounces the confirm button,
// synchronizes the tone/note switches and issues exactly one 'ok' strobe per
// accepted press with tom/nota registered alongside. Counts strobes and
// closes the sequence after a terminator note or MAX_NOTES strobes.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : note_entry_if.master (raw inputs in, ok/tom/nota/count/done out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for debounced button to go high
//   HELD    | strobe issued, waiting for debounced release
//   DONE    | sequence closed, presses ignored until reset
// -----------------------------------------------------------------------------
module note_entry
    import note_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int MAX_NOTES       = MAX_NOTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    note_entry_if.master bus
);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(MAX_NOTES);

    logic               db_level;
    logic               tom_s1_q, tom_s_q;
    logic [NOTA_W-1:0]  nota_s1_q, nota_s_q;

    state_e             state_q, state_d;
    logic               ok_q, ok_d;
    logic               tom_q, tom_d;
    logic [NOTA_W-1:0]  nota_q, nota_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q, done_d;

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .reset (reset),
        .din   (bus.btn_ok),
        .dout  (db_level)
    );

    // Switches are only synchronized; they are sampled at the strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            tom_s1_q  <= 1'b0;
            tom_s_q   <= 1'b0;
            nota_s1_q <= '0;
            nota_s_q  <= '0;
        end else begin
            tom_s1_q  <= bus.sw_tom;
            tom_s_q   <= tom_s1_q;
            nota_s1_q <= bus.sw_nota;
            nota_s_q  <= nota_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        tom_d   = tom_q;
        nota_d  = nota_q;
        count_d = count_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                // IDLE is only entered with db_level low, so a high level here
                // is a fresh rising edge.
                if (db_level) begin
                    ok_d    = 1'b1;
                    tom_d   = tom_s_q;
                    nota_d  = nota_s_q;
                    count_d = count_q + 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!db_level) begin
                    if ((nota_q == NOTA_X) || (count_q == COUNT_LAST)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ok_q    <= 1'b0;
            tom_q   <= 1'b0;
            nota_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ok_q    <= ok_d;
            tom_q   <= tom_d;
            nota_q  <= nota_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.ok    = ok_q;
    assign bus.tom   = tom_q;
    assign bus.nota  = nota_q;
    assign bus.count = count_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_note_entry.sv
module tb_note_entry;
    import note_entry_pkg::*;

    localparam int DB   = 4;
    localparam int MAXN = 6;

    typedef struct {
        logic       tom;
        logic [2:0] nota;
        logic [2:0] count;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    note_entry_if bus ();

    note_entry #(
        .DEBOUNCE_CYCLES (DB),
        .MAX_NOTES       (MAXN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.ok === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ok: ok=1 at cycle %0d, required no strobe", cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus.tom !== e.tom || bus.nota !== e.nota || bus.count !== e.count ||
                    bus.done !== 1'b0 || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got tom=%0b nota=%03b count=%0d done=%0b cyc=%0d, required tom=%0b nota=%03b count=%0d done=0 cyc=%0d",
                             bus.tom, bus.nota, bus.count, bus.done, cyc,
                             e.tom, e.nota, e.count, e.cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.btn_ok  = 1'b0;
        wait_clk(3);
        reset       = 1'b0;
        wait_clk(1);
    endtask

    // Press with switches settled beforehand; clean press from IDLE strobes
    // DB+2 edges after the first sampling edge.
    task automatic press(input logic t, input logic [2:0] n, input int hold,
                         input int rel, input bit expect_ok, input logic [2:0] exp_cnt);
        exp_t e;
        bus.sw_tom  = t;
        bus.sw_nota = n;
        wait_clk(3);
        if (expect_ok) begin
            e.tom = t; e.nota = n; e.count = exp_cnt; e.cyc = cyc + DB + 3;
            sb_q.push_back(e);
        end
        bus.btn_ok = 1'b1;
        wait_clk(hold);
        bus.btn_ok = 1'b0;
        wait_clk(rel);
    endtask

    initial begin
        exp_t e;
        logic [2:0] seq_notes [6];
        seq_notes[0] = 3'b001; seq_notes[1] = 3'b011; seq_notes[2] = 3'b101;
        seq_notes[3] = 3'b110; seq_notes[4] = 3'b111; seq_notes[5] = 3'b000;

        reset       = 1'b1;
        bus.btn_ok  = 1'b0;
        bus.sw_tom  = 1'b0;
        bus.sw_nota = 3'b000;
        wait_clk(1);
        do_reset();
        check("rst_ok",    int'(bus.ok),    0);
        check("rst_tom",   int'(bus.tom),   0);
        check("rst_nota",  int'(bus.nota),  0);
        check("rst_count", int'(bus.count), 0);
        check("rst_done",  int'(bus.done),  0);

        // 1: single clean press
        press(1'b0, 3'b001, 12, 10, 1'b1, 3'd1);
        check("t1_count", int'(bus.count), 1);
        check("t1_nota_held", int'(bus.nota), 1);

        // 2: bounce pattern never long enough
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.btn_ok = 1'b1; wait_clk(2);
            bus.btn_ok = 1'b0; wait_clk(1);
        end
        wait_clk(10);
        check("t2_count", int'(bus.count), 0);

        // 3: long hold then second press
        do_reset();
        press(1'b0, 3'b011, 50, 10, 1'b1, 3'd1);
        press(1'b1, 3'b110, 12, 10, 1'b1, 3'd2);
        check("t3_count", int'(bus.count), 2);
        check("t3_tom",   int'(bus.tom),   1);
        check("t3_nota",  int'(bus.nota),  6);

        // 4: full sequence ending with terminator, then ignored press
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(1'b1, seq_notes[i], 8, 10, 1'b1, 3'(i + 1));
            if (i < 5) check("t4_not_done", int'(bus.done), 0);
        end
        check("t4_done",  int'(bus.done),  1);
        check("t4_count", int'(bus.count), 6);
        press(1'b0, 3'b010, 8, 10, 1'b0, 3'd0);
        check("t4_done_after7",  int'(bus.done),  1);
        check("t4_count_after7", int'(bus.count), 6);
        check("t4_nota_frozen",  int'(bus.nota),  0);
        check("t4_tom_frozen",   int'(bus.tom),   1);

        // 5: reset mid-debounce discards the press
        do_reset();
        bus.sw_nota = 3'b101;
        bus.sw_tom  = 1'b1;
        wait_clk(3);
        bus.btn_ok  = 1'b1;
        wait_clk(4);
        reset       = 1'b1;
        bus.btn_ok  = 1'b0;
        wait_clk(2);
        reset       = 1'b0;
        wait_clk(1);
        check("t5_ok",    int'(bus.ok),    0);
        check("t5_tom",   int'(bus.tom),   0);
        check("t5_nota",  int'(bus.nota),  0);
        check("t5_count", int'(bus.count), 0);
        check("t5_done",  int'(bus.done),  0);
        wait_clk(10);
        press(1'b0, 3'b100, 10, 10, 1'b1, 3'd1);
        check("t5_count_after", int'(bus.count), 1);

        // 6: note switch changes during debounce; strobe takes the late value
        do_reset();
        bus.sw_tom  = 1'b0;
        bus.sw_nota = 3'b010;
        wait_clk(3);
        e.tom = 1'b0; e.nota = 3'b100; e.count = 3'd1; e.cyc = cyc + DB + 3;
        sb_q.push_back(e);
        bus.btn_ok  = 1'b1;
        wait_clk(2);
        bus.sw_nota = 3'b100;
        wait_clk(10);
        bus.btn_ok  = 1'b0;
        wait_clk(10);
        check("t6_nota", int'(bus.nota), 4);

        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
